// File: rtl/key_conditioner.sv
// key_conditioner: synchronise, debounce and auto-repeat four buttons into prioritised one-hot move pulses.
module key_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_FIRST = 0,
  parameter int REPEAT_RATE = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] key_raw,
  input  logic       hold,
  output logic [3:0] key_pulse,
  output logic [3:0] key_level
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RMAX = REPEAT_FIRST > REPEAT_RATE ? REPEAT_FIRST : REPEAT_RATE;
  localparam int RW = $clog2(RMAX + 1);
  localparam logic [DW-1:0] DTOP = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] RFIRST = RW'(REPEAT_FIRST == 0 ? 0 : REPEAT_FIRST - 1);
  localparam logic [RW-1:0] RNEXT = RW'(REPEAT_RATE - 1);
  logic [3:0] sync1, sync2, level_d, rise, req, grant;
  logic [3:0][DW-1:0] cnt;
  logic [3:0][RW-1:0] rcnt;
  always_comb begin
    rise = key_level & ~level_d;
    for (int k = 0; k < 4; k++)
      req[k] = rise[k] | (REPEAT_FIRST != 0 && key_level[k] && level_d[k] && rcnt[k] == '0);
    grant = req[0] ? 4'b0001 : req[3] ? 4'b1000 : req[2] ? 4'b0100 : req[1] ? 4'b0010 : 4'b0000;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      level_d <= '0;
      key_level <= '0;
      key_pulse <= '0;
      cnt <= '0;
      rcnt <= '0;
    end else begin
      sync1 <= key_raw;
      sync2 <= sync1;
      level_d <= key_level;
      key_pulse <= hold ? 4'b0000 : grant;
      for (int k = 0; k < 4; k++) begin
        if (sync2[k] == key_level[k]) cnt[k] <= '0;
        else if (cnt[k] == DTOP) begin
          key_level[k] <= sync2[k];
          cnt[k] <= '0;
        end else cnt[k] <= cnt[k] + DW'(1);
        // timers advance on every request, granted or not, so losers stay on schedule
        if (!key_level[k]) rcnt[k] <= '0;
        else if (rise[k]) rcnt[k] <= RFIRST;
        else if (rcnt[k] == '0) rcnt[k] <= RNEXT;
        else rcnt[k] <= rcnt[k] - RW'(1);
      end
    end
  end
endmodule

// File: tb/tb_key_conditioner.sv
// tb_key_conditioner: per-edge vector scenarios checked through an expectation queue.
module tb_key_conditioner;
  logic clk = 0, reset = 1, hold = 0;
  logic [3:0] key_raw = '0;
  logic [3:0] p0, l0, p8, l8;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  key_conditioner #(.DEBOUNCE_CYCLES(4), .REPEAT_FIRST(0), .REPEAT_RATE(3)) dut0 (
    .clk(clk), .reset(reset), .key_raw(key_raw), .hold(hold), .key_pulse(p0), .key_level(l0));
  key_conditioner #(.DEBOUNCE_CYCLES(4), .REPEAT_FIRST(8), .REPEAT_RATE(3)) dut8 (
    .clk(clk), .reset(reset), .key_raw(key_raw), .hold(hold), .key_pulse(p8), .key_level(l8));
  typedef struct {
    string name;
    bit d8;
    logic [3:0] keys;
    logic [63:0] raw_mask;
    int hold_end;
    int rst_at;
    int n;
    logic [63:0] pulse_mask;
    logic [3:0] pv;
    int r1, f1, r2, f2;
  } vec_t;
  typedef struct {
    string name;
    int e;
    bit d8;
    logic [3:0] pulse;
    logic [3:0] level;
  } exp_t;
  vec_t v[7];
  exp_t q[$];
  task automatic check(input string nm, input logic [3:0] act, input logic [3:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%b required=%b", nm, act, req);
    end
  endtask
  task automatic do_reset();
    @(negedge clk);
    reset = 1;
    key_raw = '0;
    hold = 0;
    @(negedge clk);
    reset = 0;
  endtask
  initial begin
    v[0] = '{"clean", 0, 4'b0001, 64'h0FFF, 0, -1, 22, 64'd1 << 6, 4'b0001, 5, 17, 99, 99};
    v[1] = '{"glitch", 0, 4'b0100, 64'h0007, 0, -1, 15, 64'd0, 4'b0100, 99, 99, 99, 99};
    v[2] = '{"bounce", 0, 4'b0100, 64'hFFFB, 0, -1, 14, 64'd1 << 9, 4'b0100, 8, 99, 99, 99};
    v[3] = '{"repeat", 1, 4'b1000, 64'h3FFF_FFFF, 0, -1, 31,
             (64'd1 << 6) | (64'd1 << 14) | (64'd1 << 17) | (64'd1 << 20) | (64'd1 << 23) | (64'd1 << 26) | (64'd1 << 29),
             4'b1000, 5, 99, 99, 99};
    v[4] = '{"simul", 0, 4'b1010, 64'h0FFF, 0, -1, 20, 64'd1 << 6, 4'b1000, 5, 17, 99, 99};
    v[5] = '{"hold", 1, 4'b0001, '1, 11, -1, 17, 64'd1 << 14, 4'b0001, 5, 99, 99, 99};
    v[6] = '{"reset_mid", 0, 4'b0100, '1, 0, 10, 21, (64'd1 << 6) | (64'd1 << 17), 4'b0100, 5, 10, 16, 99};
    do_reset();
    #1;
    check("reset_pulse0", p0, 4'b0000);
    check("reset_level0", l0, 4'b0000);
    check("reset_pulse8", p8, 4'b0000);
    check("reset_level8", l8, 4'b0000);
    foreach (v[i]) begin
      do_reset();
      for (int e = 0; e < v[i].n; e++) begin
        exp_t x;
        bit lv;
        @(negedge clk);
        key_raw = v[i].raw_mask[e] ? v[i].keys : 4'b0000;
        hold = e < v[i].hold_end;
        reset = e == v[i].rst_at;
        lv = (e >= v[i].r1 && e < v[i].f1) || (e >= v[i].r2 && e < v[i].f2);
        x.name = v[i].name;
        x.e = e;
        x.d8 = v[i].d8;
        x.pulse = v[i].pulse_mask[e] ? v[i].pv : 4'b0000;
        x.level = lv ? v[i].keys : 4'b0000;
        q.push_back(x);
        @(posedge clk);
        #1;
        x = q.pop_front();
        check($sformatf("%s_pulse_E%0d", x.name, x.e), x.d8 ? p8 : p0, x.pulse);
        check($sformatf("%s_level_E%0d", x.name, x.e), x.d8 ? l8 : l0, x.level);
      end
    end
    // a long hold then release must end in silence once the level is low
    do_reset();
    @(negedge clk);
    key_raw = 4'b1000;
    repeat (20) @(negedge clk);
    key_raw = 4'b0000;
    repeat (8) @(negedge clk);
    for (int e = 0; e < 10; e++) begin
      @(posedge clk);
      #1;
      check($sformatf("released_quiet_%0d", e), p8, 4'b0000);
      check($sformatf("released_level_%0d", e), l8, 4'b0000);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
